// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of one single-ported memory.
// Define ARB_RR_EN for round-robin arbitration instead of data priority with starvation guard.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [3:0]  dm_size,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          win_if_q;
  logic          win_if_d;
  logic          if_gnt_q, if_rvalid_q, dm_gnt_q, dm_rvalid_q;
  logic [31:0]   if_rdata_q;
  logic [63:0]   dm_rdata_q;
  logic          mem_en_q, mem_we_q;
  logic [63:0]   mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_size_q;

`ifdef ARB_RR_EN
  logic last_if_q;
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q;
`endif

  // Winner selection for a request sampled in IDLE; 1 = fetch, 0 = data.
  always_comb begin
    win_if_d = 1'b0;
    if (if_req && !dm_req) begin
      win_if_d = 1'b1;
    end else if (if_req && dm_req) begin
`ifdef ARB_RR_EN
      win_if_d = ~last_if_q;
`else
      win_if_d = (starve_q == STARVE_LIM);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_if_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_gnt_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
`ifdef ARB_RR_EN
      last_if_q   <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || dm_req) begin
            state_q  <= ACCESS;
            cnt_q    <= CNT_INIT;
            mem_en_q <= 1'b1;
            win_if_q <= win_if_d;
`ifdef ARB_RR_EN
            last_if_q <= win_if_d;
`endif
            if (win_if_d) begin
              if_gnt_q    <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_size_q  <= 4'd4;
`ifndef ARB_RR_EN
              starve_q    <= '0;
`endif
            end else begin
              dm_gnt_q    <= 1'b1;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              mem_size_q  <= dm_size;
`ifndef ARB_RR_EN
              // Only a data win over a waiting fetch counts toward starvation.
              if (if_req && (starve_q != STARVE_LIM)) starve_q <= starve_q + 1'b1;
`endif
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            if (win_if_q) begin
              if_rdata_q  <= mem_rdata[31:0];
              if_rvalid_q <= 1'b1;
            end else begin
              dm_rdata_q  <= mem_we_q ? 64'd0 : mem_rdata;
              dm_rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign busy      = (state_q != IDLE);

endmodule
